uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_baud_tick.sv | 31 +++
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: frame state
// encodings, default bit-period counter width and default bit-period reload.
package uart_pkg;

  localparam int unsigned UART_N      = 5;   // bit-period counter width
  localparam int unsigned UART_FULL   = 29;  // clocks per bit minus one
  localparam int unsigned UART_DATA_W = 8;   // payload width
  localparam int unsigned UART_BIT_W  = 3;   // data-bit index width

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START_BIT = 2'b01,
    SENDING   = 2'b11,
    STOP_BIT  = 2'b10
  } uart_state_e;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer: N-bit down counter that reloads with Full on load,
// decrements while nonzero and never wraps. tick_c is high while it sits at zero.
// Ports: Clk, Reset (async, active-high), load (reload request), tick_c (count==0).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned   N    = UART_N,
  parameter logic [N-1:0]  Full = N'(UART_FULL)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  output logic tick_c
);

  logic [N-1:0] count;

  // Reload has priority; otherwise count down and park at zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= Full;
    end else if (count != '0) begin
      count <= count - N'(1);
    end
  end

  assign tick_c = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, double-buffered hold register with
// a four-phase Send/Busy handshake. Each bit lasts Full+1 clocks.
// Ports: Clk, Reset (async, active-high), Data[7:0] (byte, stable while Send),
//        Send (request), Busy (registered handshake ack), Tx (registered line, idle 1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned  N    = UART_N,
  parameter logic [N-1:0] Full = N'(UART_FULL)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [UART_DATA_W-1:0] Data,
  input  logic                   Send,
  output logic                   Busy,
  output logic                   Tx
);

  uart_state_e            state, state_n;
  logic [UART_DATA_W-1:0] shifter, shifter_n;
  logic [UART_DATA_W-1:0] hold, hold_n;
  logic [UART_BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic                   hold_valid, hold_valid_n;
  logic                   busy_n;
  logic                   tx_n;
  logic                   tsend;
  logic                   load_c;
  logic                   tick_c;
  logic                   capture_c;

  uart_baud_tick #(
    .N    (N),
    .Full (Full)
  ) u_baud (
    .Clk    (Clk),
    .Reset  (Reset),
    .load   (load_c),
    .tick_c (tick_c)
  );

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      shifter    <= '0;
      hold       <= '0;
      bit_cnt    <= '0;
      hold_valid <= 1'b0;
      Busy       <= 1'b0;
      Tx         <= 1'b1;
      tsend      <= 1'b0;
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      hold       <= hold_n;
      bit_cnt    <= bit_cnt_n;
      hold_valid <= hold_valid_n;
      Busy       <= busy_n;
      Tx         <= tx_n;
      tsend      <= Send;
    end
  end

  // Capture needs an empty hold register before the edge, so it can never
  // coincide with a hold-to-shifter transfer (which needs it full).
  assign capture_c = tsend && !Busy && !hold_valid;

  // Next-state, frame sequencing and handshake.
  always_comb begin
    state_n      = state;
    shifter_n    = shifter;
    hold_n       = hold;
    bit_cnt_n    = bit_cnt;
    hold_valid_n = hold_valid;
    busy_n       = Busy;
    tx_n         = Tx;
    load_c       = 1'b0;

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (hold_valid) begin
          shifter_n    = hold;
          hold_valid_n = 1'b0;
          load_c       = 1'b1;
          tx_n         = 1'b0;
          state_n      = START_BIT;
        end
      end
      START_BIT: begin
        if (tick_c) begin
          tx_n      = shifter[0];
          shifter_n = shifter >> 1;
          bit_cnt_n = '0;
          load_c    = 1'b1;
          state_n   = SENDING;
        end
      end
      SENDING: begin
        if (tick_c) begin
          load_c = 1'b1;
          if (bit_cnt == UART_BIT_W'(7)) begin
            tx_n    = 1'b1;
            state_n = STOP_BIT;
          end else begin
            tx_n      = shifter[0];
            shifter_n = shifter >> 1;
            bit_cnt_n = bit_cnt + UART_BIT_W'(1);
          end
        end
      end
      STOP_BIT: begin
        if (tick_c) begin
          // Back-to-back frames: start bit follows the stop bit with no gap.
          if (hold_valid) begin
            shifter_n    = hold;
            hold_valid_n = 1'b0;
            load_c       = 1'b1;
            tx_n         = 1'b0;
            state_n      = START_BIT;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase

    if (capture_c) begin
      hold_n       = Data;
      hold_valid_n = 1'b1;
      busy_n       = 1'b1;
    end else if (Busy && !tsend && !hold_valid) begin
      busy_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-timing instance plus a Full=3 instance
// sharing the same stimulus.
module tb_uart_tx;

  logic       Clk;
  logic       Reset;
  logic [7:0] Data;
  logic       Send;
  logic       Busy, Tx;
  logic       busy2, tx2;

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;

  uart_tx u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Data  (Data),
    .Send  (Send),
    .Busy  (Busy),
    .Tx    (Tx)
  );

  uart_tx #(.N(5), .Full(5'd3)) u_dut_fast (
    .Clk   (Clk),
    .Reset (Reset),
    .Data  (Data),
    .Send  (Send),
    .Busy  (busy2),
    .Tx    (tx2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic cur_tx();
    return sel ? tx2 : Tx;
  endfunction

  function automatic logic cur_busy();
    return sel ? busy2 : Busy;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks frame cycles [from, to) of byte b with bit period p, one per clock.
  task automatic check_part(input string tag, input logic [7:0] b, input int p,
                            input int from, input int to);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int c = from; c < to; c++) begin
      check($sformatf("%s tx c%0d", tag, c), cur_tx(), f[c / p]);
      tick();
    end
  endtask

  task automatic check_idle(input string tag, input int n, input logic exp_busy);
    for (int c = 0; c < n; c++) begin
      check($sformatf("%s idle tx c%0d", tag, c), cur_tx(), 1'b1);
      check($sformatf("%s idle busy c%0d", tag, c), cur_busy(), exp_busy);
      tick();
    end
  endtask

  // mode 0: Send for one clock; 1: drop after Busy seen; 2: keep Send high.
  // Returns positioned on the first start-bit clock.
  task automatic start_send(input string tag, input logic [7:0] b, input int mode);
    Data = b;
    Send = 1'b1;
    tick();
    check({tag, " busy@k"}, cur_busy(), 1'b0);
    check({tag, " tx@k"}, cur_tx(), 1'b1);
    if (mode == 0) Send = 1'b0;
    tick();
    check({tag, " busy@k+1"}, cur_busy(), 1'b1);
    check({tag, " tx@k+1"}, cur_tx(), 1'b1);
    if (mode == 1) Send = 1'b0;
    tick();
    check({tag, " busy@k+2"}, cur_busy(), 1'b1);
  endtask

  initial begin
    Reset = 1'b1;
    Send  = 1'b0;
    Data  = 8'h00;
    #1;
    check("reset tx", Tx, 1'b1);
    check("reset busy", Busy, 1'b0);
    check("reset tx fast", tx2, 1'b1);
    check("reset busy fast", busy2, 1'b0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check_idle("pre", 5, 1'b0);

    // Single byte from idle.
    start_send("t55", 8'h55, 1);
    check_part("t55", 8'h55, 30, 0, 1);
    check("t55 busy clear", Busy, 1'b0);
    check_part("t55", 8'h55, 30, 1, 300);
    check_idle("t55", 20, 1'b0);

    // Double-buffered back-to-back frames.
    start_send("tA3", 8'hA3, 1);
    check_part("tA3", 8'hA3, 30, 0, 1);
    check("tA3 busy clear", Busy, 1'b0);
    check_part("tA3", 8'hA3, 30, 1, 50);
    Data = 8'h3C;
    Send = 1'b1;
    check_part("tA3", 8'hA3, 30, 50, 52);
    check("t3C busy capture", Busy, 1'b1);
    Send = 1'b0;
    check_part("tA3", 8'hA3, 30, 52, 300);
    check("t3C busy held", Busy, 1'b1);
    check_part("t3C", 8'h3C, 30, 0, 1);
    check("t3C busy clear", Busy, 1'b0);
    check_part("t3C", 8'h3C, 30, 1, 300);
    check_idle("t3C", 20, 1'b0);

    // Send held high: exactly one frame, Busy held until Send drops.
    start_send("t0F", 8'h0F, 2);
    check_part("t0F", 8'h0F, 30, 0, 300);
    check_idle("t0F held", 698, 1'b1);
    Send = 1'b0;
    tick();
    check("t0F busy after drop", Busy, 1'b1);
    tick();
    check("t0F busy cleared", Busy, 1'b0);
    check_idle("t0F", 50, 1'b0);

    // Reset mid-frame with a byte held.
    start_send("tFF", 8'hFF, 1);
    check_part("tFF", 8'hFF, 30, 0, 20);
    Data = 8'h00;
    Send = 1'b1;
    check_part("tFF", 8'hFF, 30, 20, 22);
    check("t00 busy capture", Busy, 1'b1);
    Send = 1'b0;
    check_part("tFF", 8'hFF, 30, 22, 150);
    Reset = 1'b1;
    #1;
    check("rst tx", Tx, 1'b1);
    check("rst busy", Busy, 1'b0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check_idle("post rst", 400, 1'b0);

    // One-clock Send pulse.
    start_send("t96", 8'h96, 0);
    check_part("t96", 8'h96, 30, 0, 1);
    check("t96 busy clear", Busy, 1'b0);
    check_part("t96", 8'h96, 30, 1, 300);
    check_idle("t96", 320, 1'b0);

    // Short bit period instance.
    sel = 1'b1;
    start_send("fC5", 8'hC5, 1);
    check_part("fC5", 8'hC5, 4, 0, 1);
    check("fC5 busy clear", busy2, 1'b0);
    check_part("fC5", 8'hC5, 4, 1, 40);
    check_idle("fC5", 20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
